// File: rtl/fetch_state_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and memory (slave).
interface fetch_state_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic        IMEM_ACK;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_DATA,
    input  IMEM_ACK
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_DATA,
    output IMEM_ACK
  );
endinterface

// File: rtl/fetch_state.sv
// OTTER instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// drives the fetch register (FR_*) seen by decode, honouring stall, flush and redirects.
module fetch_state #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 REG_CLOCK,
  input  logic                 REG_RESET,
  input  logic                 STALL,
  input  logic                 FLUSH,
  input  logic [1:0]           PC_SOURCE,
  input  logic [31:0]          JALR_TARGET,
  input  logic [31:0]          BRANCH_TARGET,
  input  logic [31:0]          JAL_TARGET,
  fetch_state_if.master        imem,
  output logic [31:0]          FR_MEM,
  output logic [31:0]          FR_PC,
  output logic [31:0]          FR_PC_4,
  output logic                 FR_VALID
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDiscard} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic [31:0] hold_instr_q;
  logic [31:0] fr_mem_q;
  logic [31:0] fr_pc_q;
  logic [31:0] fr_pc4_q;
  logic        fr_valid_q;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redirect = (PC_SOURCE != 2'd0);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    unique case (PC_SOURCE)
      2'd1:    target_raw = JALR_TARGET;
      2'd2:    target_raw = BRANCH_TARGET;
      2'd3:    target_raw = JAL_TARGET;
      default: target_raw = pc_plus4;
    endcase
  end

  assign target = target_raw & 32'hFFFF_FFFC;

  // Gated by reset so the bus goes quiet the instant reset asserts.
  assign imem.IMEM_REQ  = REG_RESET && (state_q != StHold);
  assign imem.IMEM_ADDR = req_addr_q;

  always_ff @(posedge REG_CLOCK or negedge REG_RESET) begin
    if (!REG_RESET) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      fr_mem_q     <= NOP_INSTR;
      fr_pc_q      <= 32'd0;
      fr_pc4_q     <= 32'd0;
      fr_valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StReq, StWait: begin
          if (imem.IMEM_ACK) begin
            if (redirect) begin
              pc_q       <= target;
              req_addr_q <= target;
              fr_mem_q   <= NOP_INSTR;
              fr_valid_q <= 1'b0;
              state_q    <= StReq;
            end else if (STALL) begin
              hold_instr_q <= imem.IMEM_DATA;
              state_q      <= StHold;
              if (FLUSH) begin
                fr_mem_q   <= NOP_INSTR;
                fr_valid_q <= 1'b0;
              end
            end else begin
              if (FLUSH) begin
                fr_mem_q   <= NOP_INSTR;
                fr_valid_q <= 1'b0;
              end else begin
                fr_mem_q   <= imem.IMEM_DATA;
                fr_pc_q    <= pc_q;
                fr_pc4_q   <= pc_plus4;
                fr_valid_q <= 1'b1;
              end
              pc_q       <= pc_plus4;
              req_addr_q <= pc_plus4;
              state_q    <= StReq;
            end
          end else begin
            // Redirect without ack: the old request must still complete, so drain it.
            if (redirect) begin
              pc_q    <= target;
              state_q <= StDiscard;
            end else begin
              state_q <= StWait;
            end
            if (FLUSH || !STALL) begin
              fr_mem_q   <= NOP_INSTR;
              fr_valid_q <= 1'b0;
            end
          end
        end

        StHold: begin
          if (redirect) begin
            pc_q       <= target;
            req_addr_q <= target;
            fr_mem_q   <= NOP_INSTR;
            fr_valid_q <= 1'b0;
            state_q    <= StReq;
          end else if (FLUSH) begin
            pc_q       <= pc_plus4;
            req_addr_q <= pc_plus4;
            fr_mem_q   <= NOP_INSTR;
            fr_valid_q <= 1'b0;
            state_q    <= StReq;
          end else if (!STALL) begin
            fr_mem_q   <= hold_instr_q;
            fr_pc_q    <= pc_q;
            fr_pc4_q   <= pc_plus4;
            fr_valid_q <= 1'b1;
            pc_q       <= pc_plus4;
            req_addr_q <= pc_plus4;
            state_q    <= StReq;
          end
        end

        StDiscard: begin
          if (redirect) begin
            pc_q <= target;
          end
          if (imem.IMEM_ACK) begin
            req_addr_q <= redirect ? target : pc_q;
            state_q    <= StReq;
          end
          if (FLUSH || !STALL) begin
            fr_mem_q   <= NOP_INSTR;
            fr_valid_q <= 1'b0;
          end
        end

        default: state_q <= StReq;
      endcase
    end
  end

  assign FR_MEM   = fr_mem_q;
  assign FR_PC    = fr_pc_q;
  assign FR_PC_4  = fr_pc4_q;
  assign FR_VALID = fr_valid_q;

endmodule

// File: tb/tb_fetch_state.sv
// Directed bench for fetch_state: scripted imem responses, hand-computed FR and bus values.
module tb_fetch_state;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_source;
  logic [31:0] jalr_target;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
  logic [31:0] fr_mem;
  logic [31:0] fr_pc;
  logic [31:0] fr_pc_4;
  logic        fr_valid;

  int errors = 0;
  int checks = 0;

  fetch_state_if bus ();

  fetch_state dut (
    .REG_CLOCK     (clk),
    .REG_RESET     (rst_n),
    .STALL         (stall),
    .FLUSH         (flush),
    .PC_SOURCE     (pc_source),
    .JALR_TARGET   (jalr_target),
    .BRANCH_TARGET (branch_target),
    .JAL_TARGET    (jal_target),
    .imem          (bus),
    .FR_MEM        (fr_mem),
    .FR_PC         (fr_pc),
    .FR_PC_4       (fr_pc_4),
    .FR_VALID      (fr_valid)
  );

  always #5 clk = ~clk;

  // {valid, mem, pc, pc_4} and {req, addr}
  logic [96:0] fr_obs;
  logic [32:0] bus_obs;
  assign fr_obs  = {fr_valid, fr_mem, fr_pc, fr_pc_4};
  assign bus_obs = {bus.IMEM_REQ, bus.IMEM_ADDR};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    pc_source = 2'd0;
    jalr_target = 32'd0;
    branch_target = 32'd0;
    jal_target = 32'd0;
    bus.IMEM_ACK = 1'b0;
    bus.IMEM_DATA = 32'd0;
    tick;
    tick;
    if (bus_obs !== {1'b0, 32'h0}) begin
      $display("FAIL reset_bus: got %h want %h", bus_obs, {1'b0, 32'h0}); errors++;
    end
    checks++;
    if (fr_obs !== {1'b0, 32'h13, 32'h0, 32'h0}) begin
      $display("FAIL reset_fr: got %h want %h", fr_obs, {1'b0, 32'h13, 32'h0, 32'h0}); errors++;
    end
    checks++;
    rst_n = 1'b1;
    #1;
    if (bus_obs !== {1'b1, 32'h0}) begin
      $display("FAIL reset_first_req: got %h want %h", bus_obs, {1'b1, 32'h0}); errors++;
    end
    checks++;
  endtask

  task automatic test_zero_wait;
    logic [31:0] exp_pc;
    bus.IMEM_ACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i) * 32'd4;
      bus.IMEM_DATA = 32'h1111_0000 + exp_pc;
      tick;
      if (fr_obs !== {1'b1, 32'h1111_0000 + exp_pc, exp_pc, exp_pc + 32'd4}) begin
        $display("FAIL zw_fr%0d: got %h want %h", i, fr_obs,
                 {1'b1, 32'h1111_0000 + exp_pc, exp_pc, exp_pc + 32'd4});
        errors++;
      end
      checks++;
      if (bus_obs !== {1'b1, exp_pc + 32'd4}) begin
        $display("FAIL zw_addr%0d: got %h want %h", i, bus_obs, {1'b1, exp_pc + 32'd4});
        errors++;
      end
      checks++;
    end
  endtask

  task automatic test_latency;
    bus.IMEM_ACK = 1'b0;
    tick;
    for (int i = 0; i < 2; i++) begin
      if (bus_obs !== {1'b1, 32'h10}) begin
        $display("FAIL lat_addr%0d: got %h want %h", i, bus_obs, {1'b1, 32'h10}); errors++;
      end
      checks++;
      if (fr_obs !== {1'b0, 32'h13, 32'hC, 32'h10}) begin
        $display("FAIL lat_bubble%0d: got %h want %h", i, fr_obs, {1'b0, 32'h13, 32'hC, 32'h10});
        errors++;
      end
      checks++;
      if (i == 1) begin
        bus.IMEM_ACK = 1'b1;
        bus.IMEM_DATA = 32'hCAFE_0010;
      end
      tick;
    end
    if (fr_obs !== {1'b1, 32'hCAFE_0010, 32'h10, 32'h14}) begin
      $display("FAIL lat_fr: got %h want %h", fr_obs, {1'b1, 32'hCAFE_0010, 32'h10, 32'h14});
      errors++;
    end
    checks++;
    if (bus_obs !== {1'b1, 32'h14}) begin
      $display("FAIL lat_next: got %h want %h", bus_obs, {1'b1, 32'h14}); errors++;
    end
    checks++;
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      bus.IMEM_DATA = 32'h2222_0014 + 32'(i) * 32'd4;
      tick;
    end
    stall = 1'b1;
    bus.IMEM_DATA = 32'hDEAD_BEEF;
    tick;
    // Ack while idle in hold must be ignored.
    bus.IMEM_DATA = 32'h0BAD_0BAD;
    if (bus_obs !== {1'b0, 32'h20}) begin
      $display("FAIL stall_req0: got %h want %h", bus_obs, {1'b0, 32'h20}); errors++;
    end
    checks++;
    if (fr_obs !== {1'b1, 32'h2222_001C, 32'h1C, 32'h20}) begin
      $display("FAIL stall_fr_hold: got %h want %h", fr_obs, {1'b1, 32'h2222_001C, 32'h1C, 32'h20});
      errors++;
    end
    checks++;
    tick;
    if (bus_obs !== {1'b0, 32'h20}) begin
      $display("FAIL stall_req1: got %h want %h", bus_obs, {1'b0, 32'h20}); errors++;
    end
    checks++;
    stall = 1'b0;
    bus.IMEM_ACK = 1'b0;
    tick;
    if (fr_obs !== {1'b1, 32'hDEAD_BEEF, 32'h20, 32'h24}) begin
      $display("FAIL stall_release: got %h want %h", fr_obs, {1'b1, 32'hDEAD_BEEF, 32'h20, 32'h24});
      errors++;
    end
    checks++;
    if (bus_obs !== {1'b1, 32'h24}) begin
      $display("FAIL stall_next: got %h want %h", bus_obs, {1'b1, 32'h24}); errors++;
    end
    checks++;
  endtask

  task automatic test_flush_redirect;
    bus.IMEM_ACK = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.IMEM_DATA = 32'h2222_0024 + 32'(i) * 32'd4;
      tick;
    end
    bus.IMEM_ACK = 1'b0;
    tick;
    pc_source = 2'd2;
    branch_target = 32'h103;
    flush = 1'b1;
    tick;
    pc_source = 2'd0;
    flush = 1'b0;
    if (bus_obs !== {1'b1, 32'h40}) begin
      $display("FAIL flush_old_addr: got %h want %h", bus_obs, {1'b1, 32'h40}); errors++;
    end
    checks++;
    if (fr_obs !== {1'b0, 32'h13, 32'h3C, 32'h40}) begin
      $display("FAIL flush_bubble: got %h want %h", fr_obs, {1'b0, 32'h13, 32'h3C, 32'h40});
      errors++;
    end
    checks++;
    bus.IMEM_ACK = 1'b1;
    bus.IMEM_DATA = 32'hBADB_AD40;
    tick;
    if (bus_obs !== {1'b1, 32'h100}) begin
      $display("FAIL flush_target: got %h want %h", bus_obs, {1'b1, 32'h100}); errors++;
    end
    checks++;
    if (fr_obs !== {1'b0, 32'h13, 32'h3C, 32'h40}) begin
      $display("FAIL flush_dropped: got %h want %h", fr_obs, {1'b0, 32'h13, 32'h3C, 32'h40});
      errors++;
    end
    checks++;
    bus.IMEM_DATA = 32'h3333_0100;
    tick;
    if (fr_obs !== {1'b1, 32'h3333_0100, 32'h100, 32'h104}) begin
      $display("FAIL flush_resume: got %h want %h", fr_obs, {1'b1, 32'h3333_0100, 32'h100, 32'h104});
      errors++;
    end
    checks++;
  endtask

  task automatic test_jal_wrap;
    pc_source = 2'd3;
    jal_target = 32'hFFFF_FFFC;
    bus.IMEM_DATA = 32'h0BAD_0104;
    tick;
    pc_source = 2'd0;
    if (bus_obs !== {1'b1, 32'hFFFF_FFFC}) begin
      $display("FAIL jal_addr: got %h want %h", bus_obs, {1'b1, 32'hFFFF_FFFC}); errors++;
    end
    checks++;
    if (fr_obs !== {1'b0, 32'h13, 32'h100, 32'h104}) begin
      $display("FAIL jal_bubble: got %h want %h", fr_obs, {1'b0, 32'h13, 32'h100, 32'h104});
      errors++;
    end
    checks++;
    bus.IMEM_DATA = 32'h4444_FFFC;
    tick;
    if (fr_obs !== {1'b1, 32'h4444_FFFC, 32'hFFFF_FFFC, 32'h0}) begin
      $display("FAIL jal_wrap_fr: got %h want %h", fr_obs, {1'b1, 32'h4444_FFFC, 32'hFFFF_FFFC, 32'h0});
      errors++;
    end
    checks++;
    if (bus_obs !== {1'b1, 32'h0}) begin
      $display("FAIL jal_wrap_addr: got %h want %h", bus_obs, {1'b1, 32'h0}); errors++;
    end
    checks++;
  endtask

  task automatic test_reset_mid_wait;
    bus.IMEM_DATA = 32'h5555_0000;
    tick;
    bus.IMEM_ACK = 1'b0;
    tick;
    if (bus_obs !== {1'b1, 32'h4}) begin
      $display("FAIL rmid_wait: got %h want %h", bus_obs, {1'b1, 32'h4}); errors++;
    end
    checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if (bus_obs !== {1'b0, 32'h0}) begin
      $display("FAIL rmid_bus: got %h want %h", bus_obs, {1'b0, 32'h0}); errors++;
    end
    checks++;
    if (fr_obs !== {1'b0, 32'h13, 32'h0, 32'h0}) begin
      $display("FAIL rmid_fr: got %h want %h", fr_obs, {1'b0, 32'h13, 32'h0, 32'h0}); errors++;
    end
    checks++;
    tick;
    rst_n = 1'b1;
    #1;
    if (bus_obs !== {1'b1, 32'h0}) begin
      $display("FAIL rmid_release: got %h want %h", bus_obs, {1'b1, 32'h0}); errors++;
    end
    checks++;
    bus.IMEM_ACK = 1'b1;
    bus.IMEM_DATA = 32'h6666_0000;
    tick;
    if (fr_obs !== {1'b1, 32'h6666_0000, 32'h0, 32'h4}) begin
      $display("FAIL rmid_fetch: got %h want %h", fr_obs, {1'b1, 32'h6666_0000, 32'h0, 32'h4});
      errors++;
    end
    checks++;
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_latency;
    test_stall;
    test_flush_redirect;
    test_jal_wrap;
    test_reset_mid_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
